// File: rtl/cadder_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit adder between NREQ requesters,
// with id tracking of in-flight sums and a backpressured response channel.
module cadder_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          add_a,
    output logic [3:0]          add_b,
    input  logic [4:0]          add_z,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [4:0]          rsp_z,
    input  logic                rsp_ready
);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic [3:0]     a;
        logic [3:0]     b;
    } stage_t;

    stage_t         s1;          // operands currently presented to the adder
    stage_t         s2;          // sum currently on add_z
    logic [3:0]     op_a_q;
    logic [3:0]     op_b_q;
    logic           stale;       // op_*_q hold S2's operands, not S1's
    logic           replay_q;    // S1 operands re-presented this cycle
    logic [IDW-1:0] ptr;

    logic           stall;
    logic           gnt_en;
    logic           gnt_any;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] next_ptr;
    logic [3:0]     lane_a [NREQ];
    logic [3:0]     lane_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        assign lane_a[g] = req_a[4*g +: 4];
        assign lane_b[g] = req_b[4*g +: 4];
    end

    assign stall  = s2.valid & ~rsp_ready;
    // While S1's operands are not on the adder they must be replayed before any new issue.
    assign gnt_en = ~rst & ~stall & ~(stale & s1.valid) & ~replay_q;

    always_comb begin
        // NOTE: every variable gets a default before the loop, otherwise a latch is inferred.
        scan_idx = '0;
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(ptr) + k) % NREQ);
            if (gnt_en && !gnt_any && req_valid[scan_idx]) begin
                gnt_any       = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_id        = scan_idx;
            end
        end
    end

    assign next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    assign req_ready = gnt;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            stale    <= 1'b0;
            replay_q <= 1'b0;
            ptr      <= '0;
        end else if (stall) begin
            op_a_q   <= s2.a;
            op_b_q   <= s2.b;
            stale    <= 1'b1;
            replay_q <= 1'b0;
        end else if (stale && s1.valid) begin
            s2.valid <= 1'b0;
            op_a_q   <= s1.a;
            op_b_q   <= s1.b;
            stale    <= 1'b0;
            replay_q <= 1'b1;
        end else begin
            s2       <= s1;
            stale    <= 1'b0;
            replay_q <= 1'b0;
            if (gnt_any) begin
                s1     <= '{valid: 1'b1, id: gnt_id, a: lane_a[gnt_id], b: lane_b[gnt_id]};
                op_a_q <= lane_a[gnt_id];
                op_b_q <= lane_b[gnt_id];
                ptr    <= next_ptr;
            end else begin
                s1.valid <= 1'b0;
            end
        end
    end

    // S2's operands go straight to the adder from the first stalled cycle so add_z never moves.
    assign add_a     = stall ? s2.a : op_a_q;
    assign add_b     = stall ? s2.b : op_b_q;
    assign rsp_valid = s2.valid;
    assign rsp_id    = s2.id;
    assign rsp_z     = s2.valid ? add_z : '0;

endmodule

// File: doc/cadder_arbiter.md
Name: cadder_arbiter

Overview:
Shares one clocked 4-bit adder (registered 5-bit Z, one-cycle latency, no enable) between NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants requesters round-robin, drives the adder's A/B inputs, tracks which requester owns each in-flight result, and returns sums over one shared response channel with backpressure. It sits between the test-harness requesters and the adder instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester id (derived; do not override)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operand valid
req_a  input  4*NREQ  operand A, requester i at bits [4i+3:4i]
req_b  input  4*NREQ  operand B, same packing
req_ready  output  NREQ  one-hot grant; handshake on req_valid[i]&req_ready[i]
add_a  output  4  registered, to adder A
add_b  output  4  registered, to adder B
add_z  input  5  adder registered sum
rsp_valid  output  1  response valid
rsp_id  output  IDW  requester id owning rsp_z
rsp_z  output  5  sum, equals add_z while rsp_valid
rsp_ready  input  1  response consumer ready

Behaviour:
- Reset (async, any time): add_a=0, add_b=0, req_ready=0, rsp_valid=0, rsp_id=0, RR pointer=0, all in-flight items dropped. No response may emerge for an item accepted before reset.
- Pipeline: S1 holds the item whose operands are on add_a/add_b. S2 holds the item whose sum is on add_z. Each stage stores valid, id, a, b.
- Issue: a handshake at edge E loads that item into S1 and add_a/add_b. Adder registers at E+1, S1 moves to S2, and rsp_valid=1 in the cycle after E+1. Accept-to-response latency is 2 cycles. Throughput is 1/cycle when rsp_ready=1.
- Grant: req_ready is combinational from req_valid, the RR pointer and stall. It is at most one-hot and only asserted on a requester with req_valid=1. It is all-zero while stalled or while a replay is pending.
- Round-robin: search starts at the pointer and wraps modulo NREQ. After a grant to i, pointer=(i+1) mod NREQ. The pointer is unchanged when nothing is granted.
- Stall: stall = rsp_valid & ~rsp_ready.
  - S2 holds and add_a/add_b are driven with S2's stored a/b, so the adder recomputes the same Z.
  - S1 holds and is not lost.
  - rsp_id/rsp_z stay stable while stalled.
- Stall release (rsp_ready=1 at edge R):
  - S2 pops.
  - If S1 is valid, its operands are re-presented on add_a/add_b after R and no grant is made in that cycle (replay).
  - S1 moves to S2 at R+1, giving a one-cycle rsp_valid bubble.
  - If S1 is empty, no bubble occurs and grants resume immediately.
- Arithmetic: add_a/add_b pass requester nibbles unmodified. rsp_z = add_z, full 5 bits, no truncation. The arbiter never alters carry.
- Simultaneous events: a new grant and S2 pop in the same edge are allowed when not stalled. A requester dropping req_valid without a handshake is legal and leaves no state.
- A requester may hold req_valid with changing data. Only data at the handshake edge is used.

Test Plan:
- Single request: req 2, a=9, b=8, rsp_ready=1 -> granted the same cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_z=17 (carry set).
- All 4 requesting continuously, a=i, b=15 -> grants 0,1,2,3,0,... one per cycle; responses back-to-back with ids in the same order and z=15+i.
- Stall: stream from req 1 (a=3,b=4) then req 3 (a=15,b=15); hold rsp_ready=0 for 5 cycles -> rsp stays id1/z=7 and no grants occur. On release: id1/z=7 pops, one bubble, then id3/z=30.
- Pointer wrap: only reqs 3 and 0 valid, pointer at 3 -> order 3,0,3,0; pointer never stalls on idle requesters.
- Async reset with 2 items in flight (mid-cycle assertion) -> all outputs 0 immediately. After deassert, no stale response; the first new grant goes to requester 0.
- Exhaustive: every (a,b) in 0..15 × 0..15 from random requesters with random rsp_ready -> each response matches a+b and its issuing id; no loss, no duplication, per-requester order preserved.
